// File: rtl/ex_mem_reg_pkg.sv
// Shared constants for the EX/MEM pipeline register: writeback source
// selects and halt-freeze FSM state encoding.
package ex_mem_reg_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_SLBI = 2'b01;
    localparam logic [1:0] WB_SEL_CMP  = 2'b10;
    localparam logic [1:0] WB_SEL_PC   = 2'b11;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/ex_mem_reg_dff_en_clr.sv
// Single-bit flop with synchronous clear (highest priority) and load enable.
module dff_en_clr (
    input  logic clk_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic data_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            data_q <= 1'b0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall hold, bubble insertion, halt-freeze FSM
// and MEM forwarding. Optional counters enabled by defining EX_MEM_PERF_EN.
//
// state  | meaning
// RUN    | normal capture of execute results
// HALTED | halt instruction captured; later captures load NOPs until rst
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   alu_out_e,
    input  logic [WIDTH-1:0]   slbi_or_e,
    input  logic [WIDTH-1:0]   comparison_e,
    input  logic [WIDTH-1:0]   pc_add_e,
    input  logic [WIDTH-1:0]   store_data_e,
    input  logic               valid_e,
    input  logic               mem_read_e,
    input  logic               mem_write_e,
    input  logic               reg_write_e,
    input  logic               halt_e,
    input  logic               err_e,
    input  logic [RADDR_W-1:0] write_reg_e,
    input  logic [1:0]         wb_sel_e,
    input  logic               mem_stall,
    input  logic               bubble,
    output logic [WIDTH-1:0]   alu_out_m,
    output logic [WIDTH-1:0]   slbi_or_m,
    output logic [WIDTH-1:0]   comparison_m,
    output logic [WIDTH-1:0]   pc_add_m,
    output logic [WIDTH-1:0]   store_data_m,
    output logic               valid_m,
    output logic               mem_read_m,
    output logic               mem_write_m,
    output logic               reg_write_m,
    output logic               halt_m,
    output logic               err_m,
    output logic [RADDR_W-1:0] write_reg_m,
    output logic [1:0]         wb_sel_m,
    output logic [WIDTH-1:0]   mem_forwarded,
    output logic               mem_fwd_valid,
`ifdef EX_MEM_PERF_EN
    output logic [15:0]        stall_cnt,
    output logic [15:0]        bubble_cnt,
`endif
    output logic               halted
);

    state_e state_q, state_d;

    logic               load_en;
    logic               nop_load;
    logic               ctrl_clr;
    logic               keep_fields;
    logic [5:0]         ctrl_d;
    logic [5:0]         ctrl_q;
    logic [WIDTH-1:0]   alu_d, slbi_d, cmp_d, pc_d, store_d;
    logic [RADDR_W-1:0] wreg_d;
    logic [1:0]         wsel_d;

    assign load_en  = ~mem_stall;
    assign nop_load = (state_q == HALTED) | bubble;
    // Controls clear on a NOP only when the stage actually loads; a stall holds them.
    assign ctrl_clr = rst | (load_en & nop_load);

    assign ctrl_d = valid_e ? {1'b1, mem_read_e, mem_write_e, reg_write_e, halt_e, err_e}
                            : 6'b0;

    assign keep_fields = ~nop_load & valid_e;
    assign alu_d   = nop_load ? '0 : alu_out_e;
    assign slbi_d  = nop_load ? '0 : slbi_or_e;
    assign cmp_d   = nop_load ? '0 : comparison_e;
    assign pc_d    = nop_load ? '0 : pc_add_e;
    assign store_d = nop_load ? '0 : store_data_e;
    assign wreg_d  = keep_fields ? write_reg_e : '0;
    assign wsel_d  = keep_fields ? wb_sel_e : WB_SEL_ALU;

    dff_en_clr u_ctrl  [5:0]         (.clk_i(clk), .en_i(load_en), .clr_i(ctrl_clr), .d_i(ctrl_d),  .q_o(ctrl_q));
    dff_en_clr u_alu   [WIDTH-1:0]   (.clk_i(clk), .en_i(load_en), .clr_i(rst),      .d_i(alu_d),   .q_o(alu_out_m));
    dff_en_clr u_slbi  [WIDTH-1:0]   (.clk_i(clk), .en_i(load_en), .clr_i(rst),      .d_i(slbi_d),  .q_o(slbi_or_m));
    dff_en_clr u_cmp   [WIDTH-1:0]   (.clk_i(clk), .en_i(load_en), .clr_i(rst),      .d_i(cmp_d),   .q_o(comparison_m));
    dff_en_clr u_pc    [WIDTH-1:0]   (.clk_i(clk), .en_i(load_en), .clr_i(rst),      .d_i(pc_d),    .q_o(pc_add_m));
    dff_en_clr u_store [WIDTH-1:0]   (.clk_i(clk), .en_i(load_en), .clr_i(rst),      .d_i(store_d), .q_o(store_data_m));
    dff_en_clr u_wreg  [RADDR_W-1:0] (.clk_i(clk), .en_i(load_en), .clr_i(rst),      .d_i(wreg_d),  .q_o(write_reg_m));
    dff_en_clr u_wsel  [1:0]         (.clk_i(clk), .en_i(load_en), .clr_i(rst),      .d_i(wsel_d),  .q_o(wb_sel_m));

    assign {valid_m, mem_read_m, mem_write_m, reg_write_m, halt_m, err_m} = ctrl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (load_en && !bubble && valid_e && halt_e) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    assign halted = (state_q == HALTED);

    always_comb begin
        mem_forwarded = alu_out_m;
        case (wb_sel_m)
            WB_SEL_ALU:  mem_forwarded = alu_out_m;
            WB_SEL_SLBI: mem_forwarded = slbi_or_m;
            WB_SEL_CMP:  mem_forwarded = comparison_m;
            WB_SEL_PC:   mem_forwarded = pc_add_m;
            default:     mem_forwarded = alu_out_m;
        endcase
    end

    // Load data arrives too late to forward from MEM; the hazard unit stalls instead.
    assign mem_fwd_valid = valid_m & reg_write_m & ~mem_read_m;

`ifdef EX_MEM_PERF_EN
    logic [15:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= 16'h0000;
            bubble_cnt_q <= 16'h0000;
        end else begin
            if (mem_stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'h0001;
            end
            if (load_en && state_q == RUN && bubble && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'h0001;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register directly downstream of the execute stage.
- Captures ALU, SLBI, compare and next-PC results, store data and memory/writeback control. Supports downstream stall, bubble insertion and a halt-freeze FSM.
- Produces the MEM-stage forwarding value and qualifier consumed by execute's r1/r2 MEM forward muxes.

Parameters:
- WIDTH, 16, datapath width.
- RADDR_W, 3, register-file address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- alu_out_e  input  WIDTH  execute ALU result
- slbi_or_e  input  WIDTH  execute SLBI result
- comparison_e  input  WIDTH  execute compare result
- pc_add_e  input  WIDTH  PC+2 for link writes
- store_data_e  input  WIDTH  forwarded r2 (store data)
- valid_e  input  1  execute holds a real instruction
- mem_read_e, mem_write_e, reg_write_e, halt_e, err_e  input  1 each  control bits
- write_reg_e  input  RADDR_W  destination register
- wb_sel_e  input  2  writeback source select
- mem_stall  input  1  memory stage busy; hold contents
- bubble  input  1  insert NOP next cycle
- alu_out_m, slbi_or_m, comparison_m, pc_add_m, store_data_m  output  WIDTH each  latched data
- valid_m, mem_read_m, mem_write_m, reg_write_m, halt_m, err_m  output  1 each  latched, qualified controls
- write_reg_m  output  RADDR_W  latched destination
- wb_sel_m  output  2  latched select
- mem_forwarded  output  WIDTH  forwarding value
- mem_fwd_valid  output  1  forwarding value usable
- halted  output  1  FSM in HALTED

Behaviour:
- Reset: every output 0, FSM = RUN. Reset wins over stall and bubble.
- Latency: one cycle, execute inputs to _m outputs.
- Update priority each rising edge: rst > mem_stall (hold all) > HALTED (load NOP) > bubble (load NOP) > capture inputs.
- NOP load: valid_m=0; mem_read_m, mem_write_m, reg_write_m, halt_m, err_m = 0; data fields are don't-care but driven 0.
- Capture with valid_e=0: all controls load as 0.
- Qualification: reg_write_m, mem_read_m and mem_write_m are 1 only when valid_m=1.
- wb_sel encoding: 00 alu_out, 01 slbi_or, 10 comparison, 11 pc_add.
- mem_forwarded: combinational mux of latched data by wb_sel_m.
- mem_fwd_valid = valid_m & reg_write_m & ~mem_read_m. Load data is never forwarded from MEM; the load-use stall belongs to the hazard unit.
- FSM states:
  - RUN -> HALTED when a capture loads halt_e=1 with valid_e=1. halted=1 from the following cycle; halt_m stays 1 while held.
  - HALTED -> HALTED until rst. Later captures become NOPs, but mem_stall still holds.
- err_m is captured per instruction, not sticky.
- Simultaneous mem_stall and bubble: stall wins; bubble is dropped, because the upstream hazard logic re-asserts it.
- Reset mid-stall: cleared next edge, FSM to RUN.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- When defined, adds two 16-bit outputs:
  - stall_cnt: increments each cycle mem_stall=1 and rst=0.
  - bubble_cnt: increments each edge a NOP is loaded by bubble.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include holds:
  - WB_SEL_ALU=2'b00, WB_SEL_SLBI=2'b01, WB_SEL_CMP=2'b10, WB_SEL_PC=2'b11.
  - FSM state constants RUN=1'b0, HALTED=1'b1.
- One sub-module, dff_en_clr: single-bit flop with enable (~mem_stall) and sync clear (rst or NOP load). Instantiated as arrays per field, with the clear input tied to rst only for data fields.

Test Plan:
- rst=1 for 2 cycles with arbitrary inputs -> all outputs 0, halted=0.
- Capture valid_e=1, alu_out_e=16'h1234, reg_write_e=1, wb_sel_e=00, write_reg_e=3 -> next cycle alu_out_m=16'h1234, mem_forwarded=16'h1234, mem_fwd_valid=1, write_reg_m=3.
- Load with mem_read_e=1, reg_write_e=1 -> mem_fwd_valid=0. wb_sel_e=11, pc_add_e=16'h0042 -> mem_forwarded=16'h0042.
- mem_stall=1 for 3 cycles while inputs change -> outputs frozen at the prior values. Raising bubble during the stall -> no bubble after the stall drops; inputs are captured.
- bubble=1 with valid_e=1, mem_write_e=1 -> valid_m=0, mem_write_m=0, mem_fwd_valid=0.
- halt_e=1, valid_e=1 captured -> halted=1 next cycle. Later valid_e=1, reg_write_e=1 -> valid_m=0. rst -> halted=0.
